alu_serial_sequencer: RTL and testbench

- Bit-serial driver and collector for a one-bit ALU slice.
- Accepts a WIDTH-bit operation over a valid/ready handshake and streams operand bits LSB-first into the slice, one bit per clock.
- Holds the carry between bit-cycles in a flop and shifts the slice's Y output into a result register.
- Returns the WIDTH-bit result and the final carry over a second valid/ready handshake. Area-cheap alternative to a WIDTH-slice ripple ALU.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_bit_slice.sv | 29 ++
 rtl/alu_serial_sequencer.sv | 106 ++++++++++
 tb/tb_alu_serial_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op encodings and sequencer state type for the bit-serial ALU.
package alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: selectable Y function, with COUT always the full-adder carry.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic [1:0] s_i,
  output logic       y_o,
  output logic       cout_o
);

  logic sum_bit;

  assign sum_bit = a_i ^ b_i ^ c_i;
  assign cout_o  = (a_i & b_i) | (c_i & (a_i ^ b_i));

  always_comb begin
    y_o = sum_bit;
    case (s_i)
      OP_ADD:  y_o = sum_bit;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_PASS: y_o = a_i;
      default: y_o = sum_bit;
    endcase
  end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial sequencer: streams operands LSB-first through one ALU slice and
// collects a WIDTH-bit result plus final carry behind valid/ready handshakes.
module alu_serial_sequencer
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic             carry_q;
  logic             start_ready_q;
  logic             res_valid_q;
  logic             slice_y;
  logic             slice_cout;

  alu_bit_slice u_slice (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .c_i    (carry_q),
    .s_i    (op_q),
    .y_o    (slice_y),
    .cout_o (slice_cout)
  );

  assign result_d = {slice_y, result_q[WIDTH-1:1]};

  // Handshake flags are registered alongside the state so both read 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_sh_q        <= '0;
      b_sh_q        <= '0;
      result_q      <= '0;
      cnt_q         <= '0;
      op_q          <= OP_ADD;
      carry_q       <= 1'b0;
      start_ready_q <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          start_ready_q <= 1'b1;
          if (start_valid && start_ready_q) begin
            a_sh_q        <= a;
            b_sh_q        <= b;
            op_q          <= op;
            carry_q       <= cin;
            result_q      <= '0;
            cnt_q         <= '0;
            start_ready_q <= 1'b0;
            state_q       <= RUN;
          end
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= slice_cout;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          start_ready_q <= 1'b0;
          res_valid_q   <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign result      = result_q;
  assign cout        = carry_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Scoreboard bench for alu_serial_sequencer: directed vectors push expected
// results into a queue, a negedge monitor pops and compares on each result handshake.
module tb_alu_serial_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             cout;

  logic [WIDTH:0] expQ[$];
  int total = 0;
  int bad   = 0;

  alu_serial_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Each observed result handshake is matched against the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_result: got cout=%0b result=0x%08h, expected no result", cout, result);
      end else begin
        logic [WIDTH:0] e;
        e = expQ.pop_front();
        if ({cout, result} !== e) begin
          bad++;
          $display("[TB] FAIL result: got cout=%0b result=0x%08h, expected cout=%0b result=0x%08h",
                   cout, result, e[WIDTH], e[WIDTH-1:0]);
        end
      end
    end
  end

  task automatic waitReady();
    int n;
    n = 0;
    while (!start_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("start_ready_timeout", {63'd0, start_ready}, 64'd1);
  endtask

  // Issue one request; the expectation is queued only when the request will complete.
  task automatic applyStimulus(input logic [1:0] o, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                               input logic vc, input logic [WIDTH-1:0] expRes, input logic expCout,
                               input bit expectResult);
    waitReady();
    op = o; a = va; b = vb; cin = vc;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    if (expectResult) expQ.push_back({expCout, expRes});
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (res_valid && res_ready) break;
      n++;
    end
    if (n >= 200) checkOutput("result_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    op = 2'b00; a = '0; b = '0; cin = 1'b0;

    #12;
    checkOutput("reset_start_ready", {63'd0, start_ready}, 64'd0);
    checkOutput("reset_res_valid", {63'd0, res_valid}, 64'd0);
    checkOutput("reset_result", {31'd0, cout, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", {63'd0, start_ready}, 64'd1);

    // ADD with carry out of the top bit, plus exact latency check.
    res_ready = 1'b1;
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    repeat (WIDTH - 1) begin
      @(posedge clk); #1;
    end
    checkOutput("latency_not_early", {63'd0, res_valid}, 64'd0);
    @(posedge clk); #1;
    checkOutput("latency_on_time", {63'd0, res_valid}, 64'd1);
    waitDone();

    applyStimulus(2'b01, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 1'b0, 32'h3030_3030, 1'b1, 1'b1);
    waitDone();
    applyStimulus(2'b10, 32'h0000_FFFF, 32'h1234_0000, 1'b0, 32'h1234_FFFF, 1'b0, 1'b1);
    waitDone();
    applyStimulus(2'b11, 32'hDEAD_BEEF, 32'h2152_4110, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    waitDone();
    applyStimulus(2'b00, 32'hDEAD_BEEF, 32'h2152_4110, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
    waitDone();

    // Backpressure with a rejected request pulsed mid-RUN.
    res_ready = 1'b0;
    applyStimulus(2'b10, 32'h0000_FFFF, 32'h1234_0000, 1'b0, 32'h1234_FFFF, 1'b0, 1'b1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    op = 2'b00; a = 32'h5555_5555; b = 32'hAAAA_AAAA; cin = 1'b1;
    start_valid = 1'b1;
    checkOutput("busy_start_ready", {63'd0, start_ready}, 64'd0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    for (int i = 0; i < 200 && !res_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_result", {31'd0, cout, result}, {31'd0, 1'b0, 32'h1234_FFFF});
      checkOutput("stall_flags", {62'd0, res_valid, start_ready}, 64'd2);
    end
    res_ready = 1'b1;
    waitDone();

    // Reset partway through RUN aborts with no result.
    applyStimulus(2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (15) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abort_res_valid", {63'd0, res_valid}, 64'd0);
    checkOutput("abort_result", {31'd0, cout, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(2'b00, 32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 1'b0, 1'b1);
    waitDone();

    // Back-to-back: start_valid held high across two requests.
    waitReady();
    op = 2'b00; a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b1;
    start_valid = 1'b1;
    @(posedge clk); #1;
    checkOutput("b2b_first_accept", {63'd0, start_ready}, 64'd0);
    expQ.push_back({1'b1, 32'h0000_0001});
    op = 2'b01; a = 32'h0F0F_0F0F; b = 32'hFFFF_0000; cin = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    @(posedge clk); #1;
    checkOutput("b2b_ready_after_handshake", {63'd0, start_ready}, 64'd1);
    expQ.push_back({1'b1, 32'h0F0F_0000});
    @(posedge clk); #1;
    checkOutput("b2b_second_accept", {63'd0, start_ready}, 64'd0);
    start_valid = 1'b0;
    waitDone();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
